// File: rtl/rf_window_ctrl.sv
// Register-file window controller: tracks CWP/SWP and sequences window spills/fills to a memory stack.
// Optional RF_WIN_STATS_EN adds saturating spill_events/fill_events counters.
module rf_window_ctrl #(
  parameter int                NBITS      = 64,
  parameter int                N          = 3,
  parameter int                F          = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] STACK_BASE = 32'h0000_00FF,
  parameter int                CNT_W      = 8,
  localparam int               PW         = (F > 1) ? $clog2(F) : 1,
  localparam int               XW         = (N > 0) ? $clog2(2 * N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  output logic              op_ack,
  output logic              op_err,
  output logic              busy,
  output logic [PW-1:0]     cwp,
  output logic [PW-1:0]     swp,
  output logic              rf_spill,
  output logic              rf_fill,
  output logic [XW-1:0]     xfer_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef RF_WIN_STATS_EN
  output logic [15:0]       spill_events,
  output logic [15:0]       fill_events,
`endif
  input  logic              mem_ack
);

  localparam int OW = $clog2(F + 1);
  localparam logic [XW-1:0] XLAST = XW'(2 * N - 1);

  if (F < 2 || N < 1 || NBITS < 1) begin : g_bad_cfg
    $error("rf_window_ctrl: requires F >= 2, N >= 1, NBITS >= 1");
  end

  typedef enum logic [1:0] {IDLE, SPILL, FILL, ACK} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       cwp_q, cwp_d, swp_q, swp_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XW-1:0]       xfer_q, xfer_d;
  logic                err_q, err_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(F - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(F - 1) : p - 1'b1;
  endfunction

  // err_q also blocks sampling for one cycle so a rejected requester can drop its level.
  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    swp_d   = swp_q;
    occ_d   = occ_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!err_q) begin
          if (call_req) begin
            if (occ_q < OW'(F)) begin
              cwp_d   = ptr_inc(cwp_q);
              occ_d   = occ_q + 1'b1;
              state_d = ACK;
            end else if (cnt_q != '1) begin
              xfer_d  = '0;
              state_d = SPILL;
            end else begin
              err_d = 1'b1;
            end
          end else if (ret_req) begin
            if (occ_q > OW'(1)) begin
              cwp_d   = ptr_dec(cwp_q);
              occ_d   = occ_q - 1'b1;
              state_d = ACK;
            end else if (cnt_q != '0) begin
              swp_d   = ptr_dec(swp_q);
              xfer_d  = XLAST;
              state_d = FILL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      SPILL: begin
        if (mem_ack) begin
          sp_d = sp_q - 1'b1;
          if (xfer_q == XLAST) begin
            swp_d   = ptr_inc(swp_q);
            cwp_d   = ptr_inc(cwp_q);
            cnt_d   = cnt_q + 1'b1;
            xfer_d  = '0;
            state_d = ACK;
          end else begin
            xfer_d = xfer_q + 1'b1;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          sp_d = sp_q + 1'b1;
          if (xfer_q == '0) begin
            cwp_d   = ptr_dec(cwp_q);
            cnt_d   = cnt_q - 1'b1;
            state_d = ACK;
          end else begin
            xfer_d = xfer_q - 1'b1;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cwp_q   <= '0;
      swp_q   <= '0;
      occ_q   <= OW'(1);
      sp_q    <= STACK_BASE;
      cnt_q   <= '0;
      xfer_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      swp_q   <= swp_d;
      occ_q   <= occ_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    op_ack   = (state_q == ACK);
    op_err   = err_q;
    busy     = (state_q == SPILL) || (state_q == FILL);
    cwp      = cwp_q;
    swp      = swp_q;
    rf_spill = (state_q == SPILL);
    rf_fill  = (state_q == FILL) && mem_ack;
    xfer_idx = xfer_q;
    mem_req  = busy;
    mem_we   = (state_q == SPILL);
    mem_addr = '0;
    if (state_q == SPILL)     mem_addr = sp_q;
    else if (state_q == FILL) mem_addr = sp_q + 1'b1;
  end

`ifdef RF_WIN_STATS_EN
  logic [15:0] spill_ev_q, spill_ev_d, fill_ev_q, fill_ev_d;

  always_comb begin
    spill_ev_d = spill_ev_q;
    fill_ev_d  = fill_ev_q;
    if (state_q == SPILL && mem_ack && xfer_q == XLAST && spill_ev_q != '1)
      spill_ev_d = spill_ev_q + 1'b1;
    if (state_q == FILL && mem_ack && xfer_q == '0 && fill_ev_q != '1)
      fill_ev_d = fill_ev_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spill_ev_q <= '0;
      fill_ev_q  <= '0;
    end else begin
      spill_ev_q <= spill_ev_d;
      fill_ev_q  <= fill_ev_d;
    end
  end

  assign spill_events = spill_ev_q;
  assign fill_events  = fill_ev_q;
`endif

endmodule

// File: doc/rf_window_ctrl.md
Name: rf_window_ctrl

Overview:
Window controller for the windowed register file. Tracks the current window pointer (CWP) and saved window pointer (SWP) across subroutine call/return. On window overflow it sequences a spill of the oldest window's IN+LOCAL registers (2N words) to a memory stack. On underflow it sequences the matching fill. It sits between decode/stall logic, the register file (which receives the rf_spill/rf_fill strobes) and the data-memory port.

Parameters:
NBITS, 64, register/memory word width (sizes nothing here; kept for uniform instantiation)
N, 3, registers per IN/LOCAL/OUT block; 2N words transferred per spill/fill
F, 4, number of physical windows (≥2)
ADDR_W, 32, memory word-address width
STACK_BASE, 32'h0000_00FF, reset value of the spill stack pointer (word address, stack grows down)
CNT_W, 8, width of the spilled-window counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
call_req  in  1  level request: call (new window); held until op_ack
ret_req  in  1  level request: return (previous window); held until op_ack
op_ack  out  1  one-cycle pulse: request completed
op_err  out  1  one-cycle pulse: request rejected (underflow/stack full)
busy  out  1  high while in SPILL or FILL (core stall)
cwp  out  clog2(F)  current window pointer
swp  out  clog2(F)  oldest resident window
rf_spill  out  1  RF drives window word xfer_idx of window swp onto its memory bus
rf_fill  out  1  one-cycle strobe: RF writes mem_rdata into word xfer_idx of window swp
xfer_idx  out  clog2(2N)  word offset within the IN+LOCAL block
mem_req  out  1  memory request
mem_we  out  1  1 = write (spill), 0 = read (fill)
mem_addr  out  ADDR_W  memory word address
mem_ack  in  1  memory handshake; on a read, data is valid in the same cycle

Behaviour:
- Reset values: cwp=0, swp=0, occ=1, sp=STACK_BASE, spill_cnt=0, state IDLE. All outputs 0 except cwp/swp (0) and mem_addr (0).
- Reset mid-spill or mid-fill aborts the transfer. mem_req is low from the next cycle. No partial pointer update survives.
- Internal state: occ (resident windows, 1..F), sp, spill_cnt (windows currently on the stack).
- FSM states: IDLE, SPILL, FILL, ACK.
- Acceptance: a request is sampled only in IDLE with op_ack=0. If call_req and ret_req are both high, the call wins; the return stays pending.
- Call, occ<F: cwp←(cwp+1) mod F, occ++. op_ack is high the cycle after sampling (1-cycle latency).
- Call, occ==F, spill_cnt<2^CNT_W−1: go to SPILL with xfer_idx=0.
  - In SPILL: rf_spill=1, mem_req=1, mem_we=1, mem_addr=sp.
  - On each mem_ack: sp←sp−1 and xfer_idx++.
  - On the ack with xfer_idx=2N−1: swp←(swp+1) mod F, cwp←(cwp+1) mod F, spill_cnt++, go to ACK. occ is unchanged.
- Call, occ==F, spill_cnt saturated: op_err pulse, no state change.
- Return, occ>1: cwp←(cwp−1) mod F, occ--. 1-cycle op_ack.
- Return, occ==1, spill_cnt>0:
  - On entry to FILL: swp←(swp−1) mod F, xfer_idx=2N−1.
  - In FILL: mem_req=1, mem_we=0, mem_addr=sp+1.
  - On each mem_ack: rf_fill pulses that cycle, sp←sp+1, xfer_idx--.
  - After the xfer_idx=0 ack: cwp←(cwp−1) mod F, spill_cnt--, go to ACK. occ stays 1.
- Return, occ==1, spill_cnt==0: op_err pulse, no state change.
- ACK: op_ack=1 for one cycle, then IDLE.
- busy is high in SPILL/FILL only.
- mem_req stays asserted with stable mem_addr until mem_ack; back-to-back acks give one word per cycle.
- Wrap-around: pointers are modulo F. sp is modulo 2^ADDR_W (no protection).

Optional Feature:
RF_WIN_STATS_EN: adds ports spill_events and fill_events (out, 16 bits each). These are saturating counters, incremented on spill/fill completion and cleared by rst. Without the macro the ports are absent and no counter logic is built.

Test Plan:
- Reset (F=4, N=3) → cwp=0, swp=0, busy=0, mem_req=0; the 3 following calls each give op_ack one cycle after req, ending with cwp=3, no mem_req.
- 4th call → 6 writes, addrs 0xFF,0xFE..0xFA, xfer_idx 0..5, rf_spill high throughout; final cwp=0, swp=1, sp=0xF9, spill_cnt=1, then op_ack.
- 3 returns (cwp 0→3→2→1), then a 4th return → swp=0, 6 reads at addrs 0xFA..0xFF, xfer_idx 5..0, 6 rf_fill pulses; final cwp=0, sp=0xFF, spill_cnt=0.
- Return with occ=1 and spill_cnt=0 → op_err pulse; cwp, swp and sp unchanged; no mem_req.
- Spill with mem_ack delayed 3 cycles per word → mem_addr/xfer_idx stable while waiting, busy high for ~24 cycles; call_req and ret_req high together in IDLE → call is served first.
- rst asserted at the 3rd spill word → next cycle mem_req=0, busy=0, cwp=0, sp=0xFF.
